// File: rtl/muldiv_unit_pkg.sv
// Shared encodings for the multiply/divide unit; these match what the decode
// controller emits for MulDiv_Type and MulDiv_Write.
package muldiv_unit_pkg;

   typedef enum logic [1:0] {
      MD_MULT  = 2'b00,
      MD_MULTU = 2'b01,
      MD_DIV   = 2'b10,
      MD_DIVU  = 2'b11
   } md_type_e;

   typedef enum logic [1:0] {
      MDW_NONE = 2'b00,
      MDW_HI   = 2'b01,
      MDW_LO   = 2'b10
   } md_write_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } md_state_e;

endpackage

// File: rtl/muldiv_unit.sv
// Fixed-latency mult/div unit owning HI/LO. The result is computed at Start into
// pending registers and committed on the last busy cycle.
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [1:0]  MulDiv_Type,
   input  logic [1:0]  MulDiv_Write,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        D_muldiv,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic        Stall_MD
);

   localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int unsigned CW = $clog2(MAX_CYCLES + 1);

   md_state_e   r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic [31:0] r_pend_hi, r_pend_lo, w_pend_hi_nxt, w_pend_lo_nxt;
   logic        r_pend_vld, w_pend_vld_nxt;
   logic [31:0] r_hi, r_lo, w_hi_nxt, w_lo_nxt;

   logic               w_is_div, w_div_zero, w_div_ovf;
   logic [31:0]        w_div_b;
   logic signed [63:0] w_a_sx, w_b_sx, w_prod_s;
   logic [63:0]        w_prod_u;
   logic signed [31:0] w_quo_s, w_rem_s;
   logic [31:0]        w_quo_u, w_rem_u;
   logic [31:0]        w_res_hi, w_res_lo;

   assign w_is_div   = MulDiv_Type[1];
   assign w_div_zero = (B == 32'd0);
   // Divisor forced to 1 on zero so the datapath never sees x/0; the result is discarded.
   assign w_div_b    = w_div_zero ? 32'd1 : B;
   assign w_div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);

   assign w_a_sx   = {{32{A[31]}}, A};
   assign w_b_sx   = {{32{B[31]}}, B};
   assign w_prod_s = w_a_sx * w_b_sx;
   assign w_prod_u = {32'd0, A} * {32'd0, B};
   assign w_quo_s  = $signed(A) / $signed(w_div_b);
   assign w_rem_s  = $signed(A) % $signed(w_div_b);
   assign w_quo_u  = A / w_div_b;
   assign w_rem_u  = A % w_div_b;

   always_comb begin
      w_res_hi = 32'd0;
      w_res_lo = 32'd0;
      case (md_type_e'(MulDiv_Type))
         MD_MULT:  {w_res_hi, w_res_lo} = w_prod_s;
         MD_MULTU: {w_res_hi, w_res_lo} = w_prod_u;
         MD_DIV: begin
            if (w_div_ovf) begin
               w_res_lo = 32'h8000_0000;
               w_res_hi = 32'd0;
            end else begin
               w_res_lo = w_quo_s;
               w_res_hi = w_rem_s;
            end
         end
         MD_DIVU: begin
            w_res_lo = w_quo_u;
            w_res_hi = w_rem_u;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_pend_hi_nxt  = r_pend_hi;
      w_pend_lo_nxt  = r_pend_lo;
      w_pend_vld_nxt = r_pend_vld;
      w_hi_nxt       = r_hi;
      w_lo_nxt       = r_lo;
      case (r_state)
         ST_IDLE: begin
            if (Start) begin
               w_pend_hi_nxt  = w_res_hi;
               w_pend_lo_nxt  = w_res_lo;
               w_pend_vld_nxt = !(w_is_div && w_div_zero);
               w_cnt_nxt      = w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
               w_state_nxt    = ST_BUSY;
            end else begin
               case (md_write_e'(MulDiv_Write))
                  MDW_HI:  w_hi_nxt = A;
                  MDW_LO:  w_lo_nxt = A;
                  default: ;
               endcase
            end
         end
         ST_BUSY: begin
            w_cnt_nxt = r_cnt - CW'(1);
            if (r_cnt <= CW'(1)) begin
               w_cnt_nxt   = '0;
               w_state_nxt = ST_IDLE;
               if (r_pend_vld) begin
                  w_hi_nxt = r_pend_hi;
                  w_lo_nxt = r_pend_lo;
               end
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_pend_hi  <= 32'd0;
         r_pend_lo  <= 32'd0;
         r_pend_vld <= 1'b0;
         r_hi       <= 32'd0;
         r_lo       <= 32'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_pend_hi  <= w_pend_hi_nxt;
         r_pend_lo  <= w_pend_lo_nxt;
         r_pend_vld <= w_pend_vld_nxt;
         r_hi       <= w_hi_nxt;
         r_lo       <= w_lo_nxt;
      end
   end

   assign Busy     = (r_state == ST_BUSY);
   assign HI       = r_hi;
   assign LO       = r_lo;
   assign Stall_MD = D_muldiv & (Start | Busy);

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, arithmetic, HI/LO moves, stall and reset abort.
module tb_muldiv_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        Start;
   logic [1:0]  MulDiv_Type;
   logic [1:0]  MulDiv_Write;
   logic [31:0] A, B;
   logic        D_muldiv;
   logic        Busy;
   logic [31:0] HI, LO;
   logic        Stall_MD;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk          (clk),
      .reset        (reset),
      .Start        (Start),
      .MulDiv_Type  (MulDiv_Type),
      .MulDiv_Write (MulDiv_Write),
      .A            (A),
      .B            (B),
      .D_muldiv     (D_muldiv),
      .Busy         (Busy),
      .HI           (HI),
      .LO           (LO),
      .Stall_MD     (Stall_MD)
   );

   always #5 clk = ~clk;

   // Pulse Start for one edge; returns 1ns after the Start edge.
   task automatic start_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      Start = 1'b1; MulDiv_Type = t; A = a; B = b;
      @(posedge clk); #1;
      Start = 1'b0;
   endtask

   task automatic move(input logic [1:0] w, input logic [31:0] a);
      @(negedge clk);
      MulDiv_Write = w; A = a;
      @(posedge clk); #1;
      MulDiv_Write = 2'b00;
   endtask

   // Counts busy cycles (bounded) and notes any HI/LO change while busy.
   task automatic count_busy(output int n, output logic changed);
      logic [31:0] hi0, lo0;
      hi0 = HI; lo0 = LO; n = 0; changed = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (Busy !== 1'b1) break;
         n++;
         if (HI !== hi0 || LO !== lo0) changed = 1'b1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1; Start = 1'b0; MulDiv_Type = 2'b00; MulDiv_Write = 2'b00;
      A = 32'd0; B = 32'd0; D_muldiv = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
      checks++; if (HI !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", HI); end
      checks++; if (LO !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", LO); end
      checks++; if (Stall_MD !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", Stall_MD); end
   endtask

   task automatic test_mult;
      int n; logic ch;
      start_op(2'b00, 32'hFFFF_FFFD, 32'd5);
      count_busy(n, ch);
      checks++; if (n != 5) begin errors++; $display("FAIL mult_latency: got %0d want 5", n); end
      checks++; if (ch !== 1'b0) begin errors++; $display("FAIL mult_hold: got changed=%b want 0", ch); end
      checks++; if (HI !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", HI); end
      checks++; if (LO !== 32'hFFFF_FFF1) begin errors++; $display("FAIL mult_lo: got %h want fffffff1", LO); end
      start_op(2'b01, 32'hFFFF_FFFF, 32'd2);
      count_busy(n, ch);
      checks++; if ({HI, LO} !== 64'h0000_0001_FFFF_FFFE) begin
         errors++; $display("FAIL multu: got %h_%h want 00000001_fffffffe", HI, LO);
      end
   endtask

   task automatic test_div;
      int n; logic ch;
      start_op(2'b11, 32'd7, 32'd2);
      count_busy(n, ch);
      checks++; if (n != 10) begin errors++; $display("FAIL divu_latency: got %0d want 10", n); end
      checks++; if (LO !== 32'd3 || HI !== 32'd1) begin
         errors++; $display("FAIL divu: got hi=%h lo=%h want hi=1 lo=3", HI, LO);
      end
      start_op(2'b10, 32'hFFFF_FFF9, 32'd2);
      count_busy(n, ch);
      checks++; if (LO !== 32'hFFFF_FFFD || HI !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL div_neg: got hi=%h lo=%h want hi=ffffffff lo=fffffffd", HI, LO);
      end
   endtask

   task automatic test_div_zero;
      int n; logic ch;
      move(2'b01, 32'h11);
      move(2'b10, 32'h22);
      start_op(2'b10, 32'd99, 32'd0);
      count_busy(n, ch);
      checks++; if (n != 10) begin errors++; $display("FAIL divzero_latency: got %0d want 10", n); end
      checks++; if (HI !== 32'h11 || LO !== 32'h22) begin
         errors++; $display("FAIL divzero_keep: got hi=%h lo=%h want hi=11 lo=22", HI, LO);
      end
      start_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
      count_busy(n, ch);
      checks++; if (LO !== 32'h8000_0000 || HI !== 32'd0) begin
         errors++; $display("FAIL div_ovf: got hi=%h lo=%h want hi=0 lo=80000000", HI, LO);
      end
   endtask

   task automatic test_mthi_mtlo;
      int n; logic ch;
      move(2'b01, 32'h1234);
      move(2'b10, 32'h5678);
      @(negedge clk);
      checks++; if (HI !== 32'h1234 || LO !== 32'h5678) begin
         errors++; $display("FAIL mthi_mtlo: got hi=%h lo=%h want hi=1234 lo=5678", HI, LO);
      end
      start_op(2'b00, 32'd2, 32'd3);
      move(2'b01, 32'hDEAD);
      checks++; if (HI !== 32'h1234) begin errors++; $display("FAIL mthi_busy_early: got %h want 1234", HI); end
      count_busy(n, ch);
      checks++; if (HI !== 32'd0 || LO !== 32'd6) begin
         errors++; $display("FAIL mthi_busy: got hi=%h lo=%h want hi=0 lo=6", HI, LO);
      end
   endtask

   task automatic test_start_wins;
      int n; logic ch;
      @(negedge clk);
      Start = 1'b1; MulDiv_Type = 2'b01; A = 32'h10; B = 32'h10; MulDiv_Write = 2'b01;
      @(posedge clk); #1;
      Start = 1'b0; MulDiv_Write = 2'b00;
      count_busy(n, ch);
      checks++; if (ch !== 1'b0) begin errors++; $display("FAIL start_wins_hold: got changed=%b want 0", ch); end
      checks++; if (HI !== 32'd0 || LO !== 32'h100) begin
         errors++; $display("FAIL start_wins: got hi=%h lo=%h want hi=0 lo=100", HI, LO);
      end
   endtask

   task automatic test_stall;
      int n;
      @(negedge clk);
      Start = 1'b1; MulDiv_Type = 2'b00; A = 32'd1; B = 32'd1; D_muldiv = 1'b0;
      #1;
      checks++; if (Stall_MD !== 1'b0) begin errors++; $display("FAIL stall_nodep: got %b want 0", Stall_MD); end
      D_muldiv = 1'b1;
      #1;
      checks++; if (Stall_MD !== 1'b1) begin errors++; $display("FAIL stall_start: got %b want 1", Stall_MD); end
      @(posedge clk); #1;
      Start = 1'b0;
      n = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (Busy !== 1'b1) break;
         n++;
         checks++; if (Stall_MD !== 1'b1) begin
            errors++; $display("FAIL stall_busy%0d: got %b want 1", n, Stall_MD);
         end
      end
      checks++; if (n != 5) begin errors++; $display("FAIL stall_latency: got %0d want 5", n); end
      checks++; if (Stall_MD !== 1'b0) begin errors++; $display("FAIL stall_release: got %b want 0", Stall_MD); end
      D_muldiv = 1'b0;
   endtask

   task automatic test_reset_abort;
      start_op(2'b11, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before: got %b want 1", Busy); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         errors++; $display("FAIL abort: got busy=%b hi=%h lo=%h want 0/0/0", Busy, HI, LO);
      end
      repeat (12) @(negedge clk);
      checks++; if (Busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         errors++; $display("FAIL abort_late: got busy=%b hi=%h lo=%h want 0/0/0", Busy, HI, LO);
      end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_div;
      test_div_zero;
      test_mthi_mtlo;
      test_start_wins;
      test_stall;
      test_reset_abort;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
